// File: rtl/ldpc_pkg.sv
// Shared constants, write-side FSM states and helpers for the LDPC LLR buffer controller.
package ldpc_pkg;

   localparam int LDPC_WORDS_PER_FRAME = 256;
   localparam int LDPC_LLR_W           = 6;
   localparam int LDPC_LLRS_PER_WORD   = 36;
   localparam int LDPC_WORD_W          = LDPC_LLR_W * LDPC_LLRS_PER_WORD;
   localparam int LDPC_DROP_CNT_W      = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DROP = 2'd2
   } wr_state_e;

   // Saturating increment of the dropped-frame counter.
   function automatic logic [LDPC_DROP_CNT_W-1:0] sat_inc8(input logic [LDPC_DROP_CNT_W-1:0] v);
      sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ldpc_llr_buf_ctrl.sv
// Ping-pong LLR RAM write sequencer: bank allocation, write addressing, decoder
// start/done handshake, overflow and short-frame detection.
module ldpc_llr_buf_ctrl
   import ldpc_pkg::*;
#(
   parameter int WORDS_PER_FRAME = LDPC_WORDS_PER_FRAME,
   parameter int AW              = 8,
   parameter int DW              = LDPC_WORD_W
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          frame_start,
   input  logic          word_valid,
   input  logic [DW-1:0] word_data,
   input  logic          dec_done,
   output logic          ram_we,
   output logic          ram_bank,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          dec_start,
   output logic          dec_bank,
   output logic          overflow,
   output logic          short_frame,
   output logic [7:0]    drop_cnt
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS_PER_FRAME - 1);

   wr_state_e     r_state, w_state_nxt;
   logic [1:0]    r_full, w_full_nxt, w_set_full, w_clr_full;
   logic          r_wr_bank, w_wr_bank_nxt;
   logic [AW-1:0] r_addr, w_addr_nxt;
   logic          r_dec_bank, w_dec_bank_nxt;
   logic          r_dec_busy, w_dec_busy_nxt;
   logic [7:0]    r_drop_cnt, w_drop_cnt_nxt;
   logic          r_ram_we, w_ram_we_nxt;
   logic          r_ram_bank, w_ram_bank_nxt;
   logic [AW-1:0] r_ram_addr, w_ram_addr_nxt;
   logic [DW-1:0] r_ram_wdata, w_ram_wdata_nxt;
   logic          r_dec_start, w_dec_start_nxt;
   logic          r_overflow, w_overflow_nxt;
   logic          r_short_frame, w_short_frame_nxt;

   // Write-side FSM next state, write port and drop accounting
   always_comb begin
      w_state_nxt       = r_state;
      w_addr_nxt        = r_addr;
      w_wr_bank_nxt     = r_wr_bank;
      w_set_full        = 2'b00;
      w_ram_we_nxt      = 1'b0;
      w_ram_bank_nxt    = r_ram_bank;
      w_ram_addr_nxt    = r_ram_addr;
      w_ram_wdata_nxt   = r_ram_wdata;
      w_overflow_nxt    = 1'b0;
      w_short_frame_nxt = 1'b0;
      w_drop_cnt_nxt    = r_drop_cnt;
      case (r_state)
         IDLE, DROP: begin
            // Words arriving here belong to no accepted frame and are discarded.
            if (frame_start) begin
               if (!r_full[r_wr_bank]) begin
                  w_state_nxt = FILL;
                  w_addr_nxt  = {AW{1'b0}};
               end else begin
                  w_state_nxt    = DROP;
                  w_overflow_nxt = 1'b1;
                  w_drop_cnt_nxt = sat_inc8(r_drop_cnt);
               end
            end else begin
               w_state_nxt = r_state;
            end
         end
         FILL: begin
            if (frame_start) begin
               w_short_frame_nxt = 1'b1;
               w_drop_cnt_nxt    = sat_inc8(r_drop_cnt);
               w_addr_nxt        = {AW{1'b0}};
            end else if (word_valid) begin
               w_ram_we_nxt    = 1'b1;
               w_ram_bank_nxt  = r_wr_bank;
               w_ram_addr_nxt  = r_addr;
               w_ram_wdata_nxt = word_data;
               if (r_addr == LAST_ADDR) begin
                  w_set_full[r_wr_bank] = 1'b1;
                  w_wr_bank_nxt         = ~r_wr_bank;
                  w_addr_nxt            = {AW{1'b0}};
                  w_state_nxt           = IDLE;
               end else begin
                  w_addr_nxt = r_addr + AW'(1);
               end
            end else begin
               w_addr_nxt = r_addr;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_addr_nxt  = {AW{1'b0}};
         end
      endcase
   end

   // Decoder handshake: start a full bank when idle, release it on dec_done
   always_comb begin
      w_dec_start_nxt = 1'b0;
      w_dec_busy_nxt  = r_dec_busy;
      w_dec_bank_nxt  = r_dec_bank;
      w_clr_full      = 2'b00;
      if (r_dec_busy) begin
         if (dec_done) begin
            w_clr_full[r_dec_bank] = 1'b1;
            w_dec_bank_nxt         = ~r_dec_bank;
            w_dec_busy_nxt         = 1'b0;
         end else begin
            w_dec_busy_nxt = 1'b1;
         end
      end else if (r_full[r_dec_bank]) begin
         w_dec_start_nxt = 1'b1;
         w_dec_busy_nxt  = 1'b1;
      end else begin
         w_dec_busy_nxt = 1'b0;
      end
   end

   // The writer only ever sets an empty bank and the decoder only clears a full one,
   // so the two never target the same flag in one cycle.
   assign w_full_nxt = (r_full & ~w_clr_full) | w_set_full;

   // Write-side FSM state register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Bank bookkeeping, counters and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_full        <= 2'b00;
         r_wr_bank     <= 1'b0;
         r_addr        <= {AW{1'b0}};
         r_dec_bank    <= 1'b0;
         r_dec_busy    <= 1'b0;
         r_drop_cnt    <= 8'd0;
         r_ram_we      <= 1'b0;
         r_ram_bank    <= 1'b0;
         r_ram_addr    <= {AW{1'b0}};
         r_ram_wdata   <= {DW{1'b0}};
         r_dec_start   <= 1'b0;
         r_overflow    <= 1'b0;
         r_short_frame <= 1'b0;
      end else begin
         r_full        <= w_full_nxt;
         r_wr_bank     <= w_wr_bank_nxt;
         r_addr        <= w_addr_nxt;
         r_dec_bank    <= w_dec_bank_nxt;
         r_dec_busy    <= w_dec_busy_nxt;
         r_drop_cnt    <= w_drop_cnt_nxt;
         r_ram_we      <= w_ram_we_nxt;
         r_ram_bank    <= w_ram_bank_nxt;
         r_ram_addr    <= w_ram_addr_nxt;
         r_ram_wdata   <= w_ram_wdata_nxt;
         r_dec_start   <= w_dec_start_nxt;
         r_overflow    <= w_overflow_nxt;
         r_short_frame <= w_short_frame_nxt;
      end
   end

   assign ram_we      = r_ram_we;
   assign ram_bank    = r_ram_bank;
   assign ram_addr    = r_ram_addr;
   assign ram_wdata   = r_ram_wdata;
   assign dec_start   = r_dec_start;
   assign dec_bank    = r_dec_bank;
   assign overflow    = r_overflow;
   assign short_frame = r_short_frame;
   assign drop_cnt    = r_drop_cnt;

endmodule

// File: doc/ldpc_llr_buf_ctrl.md
Name: ldpc_llr_buf_ctrl

Overview:
- Sequences the 216-bit packed LLR words (36 × 6-bit soft values) produced by the LDPC input packer into a two-bank ping-pong LLR RAM.
- Hands each completed frame to the LDPC decoder core.
- Sits between the input packer and the decoder.
- Owns bank allocation, the write address, the frame-complete/decoder-start handshake, and overflow and short-frame detection.

Parameters:
- WORDS_PER_FRAME, 256, packed words per LDPC codeword (9216 bits / 36).
- AW, 8, RAM word-address width; must satisfy 2^AW >= WORDS_PER_FRAME.
- DW, 216, packed word width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset. Synchronous, active-low: sampled only on the rising edge of clk.
- frame_start  in  1  one-cycle pulse from the packer at a new frame (packer internal state cleared).
- word_valid  in  1  one-cycle pulse: word_data holds a complete packed word.
- word_data  in  DW  packed LLR word, oldest LLR in the LSBs.
- dec_done  in  1  one-cycle pulse from the decoder: current bank released.
- ram_we  out  1  LLR RAM write enable.
- ram_bank  out  1  bank selected for the write.
- ram_addr  out  AW  write word address.
- ram_wdata  out  DW  write data.
- dec_start  out  1  one-cycle pulse: bank dec_bank holds a full frame.
- dec_bank  out  1  bank the decoder must read; stable from dec_start until dec_done.
- overflow  out  1  one-cycle pulse: frame dropped, no free bank.
- short_frame  out  1  one-cycle pulse: frame aborted before WORDS_PER_FRAME words.
- drop_cnt  out  8  saturating count of dropped plus aborted frames.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; full[1:0]=0; wr_bank=0; dec_bank=0; dec_busy=0; addr=0; drop_cnt=0.
- Reset values of outputs: ram_we, dec_start, overflow, short_frame = 0; ram_bank=0; ram_addr=0; ram_wdata=0.
- A reset asserted mid-frame discards the frame in progress and frees both banks, with no pulses.
- Write-side FSM states: IDLE, FILL, DROP.
- IDLE:
  - word_valid is ignored.
  - On frame_start: if full[wr_bank]=0, go to FILL with addr=0. Otherwise go to DROP, pulse overflow, and increment drop_cnt.
- FILL:
  - On word_valid: ram_we=1, ram_bank=wr_bank, ram_addr=addr, ram_wdata=word_data, all registered. Latency is exactly 1 cycle from word_valid. Then addr increments.
  - On the word with addr=WORDS_PER_FRAME-1, at the same edge as that write: full[wr_bank]=1, wr_bank toggles, addr=0, state goes to IDLE.
- DROP:
  - All words are ignored.
  - On frame_start, re-evaluate exactly as from IDLE.
- frame_start in FILL:
  - Pulse short_frame and increment drop_cnt.
  - Restart at addr=0 on the same bank; the bank is not marked full.
- frame_start and word_valid in the same cycle: frame_start wins and the word is discarded. In FILL this counts as a short frame, even if it would have been the last word.
- Decoder side:
  - When dec_busy=0 and full[dec_bank]=1, pulse dec_start and set dec_busy=1.
  - Earliest dec_start is the cycle after the last ram_we of the frame.
  - On dec_done with dec_busy=1: full[dec_bank]=0, dec_bank toggles, dec_busy=0.
  - dec_done with dec_busy=0 is ignored.
  - A bank freed by dec_done is available to a frame_start in the following cycle, not the same cycle.
- Banks are filled and consumed strictly alternately; frames are delivered in arrival order.
- drop_cnt saturates at 255.
- An idle word_valid (no frame_start seen since reset) never writes RAM.

Decomposition:
- Package ldpc_pkg holds: LDPC_WORDS_PER_FRAME=256, LDPC_LLR_W=6, LDPC_LLRS_PER_WORD=36, LDPC_WORD_W=216, and the write-FSM state enum {IDLE, FILL, DROP}.
- No sub-module is needed. Bank bookkeeping (full flags plus the two toggling pointers) stays inline; it is under 40 lines.

Test Plan (WORDS_PER_FRAME=4 for speed):
1. Single frame: frame_start, then 4 word_valid with data 1–4 → ram_we at addr 0..3 on bank 0, each 1 cycle after its word; dec_start the cycle after addr 3; dec_bank=0.
2. Ping-pong: two back-to-back frames, dec_done withheld → frame 2 written to bank 1. dec_done → dec_start for bank 1 on the next cycle. Third frame_start after a second dec_done → writes go to bank 0.
3. Overflow: both banks full, dec_done not given, frame_start → overflow pulse, drop_cnt=1, no ram_we for its 4 words. dec_done then a new frame_start → fills the freed bank 0.
4. Short frame: frame_start, 2 words, frame_start, 4 words → short_frame pulse, drop_cnt=1, second frame writes addr 0..3 on bank 0, one dec_start.
5. Collision: frame_start and the 4th word_valid in the same cycle → short_frame, no full set, no dec_start.
6. Reset mid-FILL after 2 words → all outputs at reset values the next cycle, full=0; a subsequent frame writes bank 0 from addr 0. Spurious dec_done while idle → no change.
